grid_io_bank_cfg: RTL and testbench

//  Parametrised successor of the single-pad IO grid tile. Serves NUM_IO pads from one

---
 rtl/grid_io_bank_cfg.sv | 121 ++++++++++++
 tb/tb_grid_io_bank_cfg.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_io_bank_cfg.sv
// grid_io_bank_cfg
//   IO grid tile serving NUM_IO pads from one configuration-chain segment.
//   Each pad channel carries CFG_BITS config bits: bit0 = DIR_IN (1: pad->fabric),
//   bit1 = INV (invert data). The serial chain fills a shadow register; the
//   shadow is copied into the active register only at the end of a complete,
//   error-free load window.
//
//   Optional feature macro: GRID_IO_CFG_PARITY_EN
//     Adds one odd-parity bit at sh[0] (the last bit shifted in). A window is
//     only applied when the XOR of all shadow bits is 1.
//
// Ports
//   prog_clk                        clock
//   pReset_n                        synchronous active-low reset
//   IO_ISOL_N                       0 = isolate all pads
//   config_enable                   1 = shift one config bit per cycle
//   ccff_head / ccff_tail           serial config in / out (last shadow bit)
//   gfpga_pad_sofa_plus_io_SOC_IN   pad -> fabric data
//   gfpga_pad_sofa_plus_io_SOC_OUT  fabric -> pad data
//   gfpga_pad_sofa_plus_io_SOC_DIR  1 = pad is input
//   io_outpad / io_inpad            fabric drive / receive per channel
//   cfg_valid                       active config holds a good load
//   cfg_err                         last load window was bad
module grid_io_bank_cfg #(
  parameter int NUM_IO   = 4,
  parameter int CFG_BITS = 2,
  parameter int CNT_W    = $clog2(NUM_IO*CFG_BITS+2)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              IO_ISOL_N,
  input  logic              config_enable,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic [NUM_IO-1:0] gfpga_pad_sofa_plus_io_SOC_IN,
  output logic [NUM_IO-1:0] gfpga_pad_sofa_plus_io_SOC_OUT,
  output logic [NUM_IO-1:0] gfpga_pad_sofa_plus_io_SOC_DIR,
  input  logic [NUM_IO-1:0] io_outpad,
  output logic [NUM_IO-1:0] io_inpad,
  output logic              cfg_valid,
  output logic              cfg_err
);

  localparam int NB = NUM_IO*CFG_BITS;
`ifdef GRID_IO_CFG_PARITY_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  localparam int L = NB + OFF;
  localparam logic [CNT_W-1:0] L_C = CNT_W'(L);

  logic [L-1:0]     sh;
  logic [NB-1:0]    act;
  logic [CNT_W-1:0] cnt;
  logic             en_q;
  logic             parity_ok;
  logic             iso;

`ifdef GRID_IO_CFG_PARITY_EN
  assign parity_ok = ^sh;
`else
  assign parity_ok = 1'b1;
`endif

  // The tail is the last shadow flop, so it is registered by construction.
  assign ccff_tail = sh[L-1];

  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      sh        <= '0;
      act       <= '0;
      cnt       <= '0;
      en_q      <= 1'b0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      en_q <= config_enable;
      if (config_enable) begin
        sh <= {sh[L-2:0], ccff_head};
        if (!en_q) begin
          // window start: this shift is bit 1 of the new load
          cnt     <= CNT_W'(1);
          cfg_err <= 1'b0;
        end else if (cnt < L_C) begin
          cnt <= cnt + 1'b1;
        end else begin
          // overshift: the chain already holds L bits
          cfg_err <= 1'b1;
        end
      end else if (en_q) begin
        // apply cycle: previous active config survives any bad window
        if (cnt == L_C && !cfg_err && parity_ok) begin
          act       <= sh[OFF +: NB];
          cfg_valid <= 1'b1;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

  // Pads stay isolated while shifting so a half-loaded chain never drives pins.
  assign iso = !IO_ISOL_N || config_enable || !cfg_valid;

  always_comb begin
    gfpga_pad_sofa_plus_io_SOC_OUT = '0;
    gfpga_pad_sofa_plus_io_SOC_DIR = '1;
    io_inpad                       = '0;
    if (!iso) begin
      for (int i = 0; i < NUM_IO; i++) begin
        gfpga_pad_sofa_plus_io_SOC_DIR[i] = act[i*CFG_BITS];
        if (act[i*CFG_BITS])
          io_inpad[i] = gfpga_pad_sofa_plus_io_SOC_IN[i] ^ act[i*CFG_BITS+1];
        else
          gfpga_pad_sofa_plus_io_SOC_OUT[i] = io_outpad[i] ^ act[i*CFG_BITS+1];
      end
    end
  end

endmodule

// File: tb/tb_grid_io_bank_cfg.sv
// Testbench for grid_io_bank_cfg (NUM_IO=4, CFG_BITS=2).
// Expected values are pushed into a scoreboard queue as stimulus is applied
// and popped against the DUT outputs once they have settled.
module tb_grid_io_bank_cfg;

`ifdef GRID_IO_CFG_PARITY_EN
  localparam int L = 9;
`else
  localparam int L = 8;
`endif

  logic       prog_clk = 1'b0;
  logic       pReset_n;
  logic       IO_ISOL_N;
  logic       config_enable;
  logic       ccff_head;
  logic       ccff_tail;
  logic [3:0] soc_in;
  logic [3:0] soc_out;
  logic [3:0] soc_dir;
  logic [3:0] io_outpad;
  logic [3:0] io_inpad;
  logic       cfg_valid;
  logic       cfg_err;

  grid_io_bank_cfg #(.NUM_IO(4), .CFG_BITS(2)) dut (
    .prog_clk                       (prog_clk),
    .pReset_n                       (pReset_n),
    .IO_ISOL_N                      (IO_ISOL_N),
    .config_enable                  (config_enable),
    .ccff_head                      (ccff_head),
    .ccff_tail                      (ccff_tail),
    .gfpga_pad_sofa_plus_io_SOC_IN  (soc_in),
    .gfpga_pad_sofa_plus_io_SOC_OUT (soc_out),
    .gfpga_pad_sofa_plus_io_SOC_DIR (soc_dir),
    .io_outpad                      (io_outpad),
    .io_inpad                       (io_inpad),
    .cfg_valid                      (cfg_valid),
    .cfg_err                        (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  typedef enum {S_DIR, S_OUT, S_INP, S_VAL, S_ERR, S_TAIL} sel_t;
  typedef struct {
    string      tag;
    sel_t       sel;
    logic [7:0] exp;
  } sb_t;

  sb_t        sbq[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] m_act;
  logic       m_valid;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] observe(input sel_t s);
    case (s)
      S_DIR:   return {4'b0, soc_dir};
      S_OUT:   return {4'b0, soc_out};
      S_INP:   return {4'b0, io_inpad};
      S_VAL:   return {7'b0, cfg_valid};
      S_ERR:   return {7'b0, cfg_err};
      default: return {7'b0, ccff_tail};
    endcase
  endfunction

  task automatic push(input string tag, input sel_t s, input logic [7:0] exp);
    sb_t e;
    e.tag = tag; e.sel = s; e.exp = exp;
    sbq.push_back(e);
  endtask

  // Reference pad behaviour from the bench's own copy of the applied config.
  task automatic push_pads(input string tag);
    logic [3:0] d, o, n;
    logic       iso;
    iso = !IO_ISOL_N || config_enable || !m_valid;
    d = 4'hF; o = 4'h0; n = 4'h0;
    if (!iso) begin
      for (int i = 0; i < 4; i++) begin
        d[i] = m_act[2*i];
        o[i] = m_act[2*i] ? 1'b0 : io_outpad[i] ^ m_act[2*i+1];
        n[i] = m_act[2*i] ? soc_in[i] ^ m_act[2*i+1] : 1'b0;
      end
    end
    push({tag, ".dir"}, S_DIR, {4'b0, d});
    push({tag, ".out"}, S_OUT, {4'b0, o});
    push({tag, ".inp"}, S_INP, {4'b0, n});
  endtask

  task automatic drain();
    sb_t e;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  // Shadow image for a channel config; with parity, sh[0] is the parity bit.
  function automatic logic [15:0] make_vec(input logic [7:0] cfg, input logic odd);
`ifdef GRID_IO_CFG_PARITY_EN
    return {7'b0, cfg, odd ? ~^cfg : ^cfg};
`else
    if (odd) return {8'b0, cfg};
    return {8'b0, cfg};
`endif
  endfunction

  // Shift n bits of the image starting at stream position first (sh[L-1] goes first).
  task automatic shift_bits(input logic [15:0] v, input int first, input int n);
    int idx;
    for (int k = 0; k < n; k++) begin
      idx = L - 1 - first - k;
      config_enable = 1'b1;
      ccff_head = (idx >= 0) ? v[idx] : 1'b0;
      step();
    end
  endtask

  task automatic end_window();
    config_enable = 1'b0;
    ccff_head = 1'b0;
    step();
  endtask

  task automatic pad_patterns(input string tag);
    logic [3:0] op [3] = '{4'b0011, 4'b1010, 4'b1100};
    logic [3:0] ip [3] = '{4'b1111, 4'b0101, 4'b0110};
    for (int p = 0; p < 3; p++) begin
      io_outpad = op[p];
      soc_in    = ip[p];
      push_pads($sformatf("%s.p%0d", tag, p));
      drain();
    end
  endtask

  logic [15:0] v;

  initial begin
    pReset_n = 1'b0; IO_ISOL_N = 1'b1; config_enable = 1'b0; ccff_head = 1'b0;
    io_outpad = 4'b1111; soc_in = 4'b1111;
    m_act = '0; m_valid = 1'b0;
    step(); step();
    pReset_n = 1'b1;

    // 1: reset state, isolated
    push("rst.dir", S_DIR, 8'h0F);
    push("rst.out", S_OUT, 8'h00);
    push("rst.inp", S_INP, 8'h00);
    push("rst.val", S_VAL, 8'h00);
    push("rst.err", S_ERR, 8'h00);
    push("rst.tail", S_TAIL, 8'h00);
    drain();

    // 2: good load, ch0..3 = {00},{01},{10},{11}
    v = make_vec(8'hD8, 1'b1);
    shift_bits(v, 0, 1);
    push_pads("t2.shift");
    drain();
    shift_bits(v, 1, L-1);
    end_window();
    m_act = 8'hD8; m_valid = 1'b1;
    io_outpad = 4'b0011; soc_in = 4'b1111;
    push("t2.val", S_VAL, 8'h01);
    push("t2.err", S_ERR, 8'h00);
    push("t2.dir", S_DIR, 8'h0C);
    push("t2.out", S_OUT, 8'h01);
    push("t2.inp", S_INP, 8'h04);
    drain();
    pad_patterns("t2");

    // isolation pin overrides a valid config in the same cycle
    IO_ISOL_N = 1'b0;
    push_pads("iso");
    push("iso.dir", S_DIR, 8'h0F);
    drain();
    IO_ISOL_N = 1'b1;

    // 3: short window keeps old config, next good window clears error
    v = make_vec(8'h00, 1'b1);
    shift_bits(v, 0, L-1);
    end_window();
    push("t3.err", S_ERR, 8'h01);
    push("t3.val", S_VAL, 8'h01);
    push("t3.dir", S_DIR, 8'h0C);
    drain();
    pad_patterns("t3.keep");
    v = make_vec(8'h27, 1'b1);
    shift_bits(v, 0, 1);
    push("t3.clr", S_ERR, 8'h00);
    drain();
    shift_bits(v, 1, L-1);
    end_window();
    m_act = 8'h27;
    push("t3.err2", S_ERR, 8'h00);
    drain();
    pad_patterns("t3.new");

    // 4: overshift by one bit
    v = make_vec(8'h7E, 1'b1);
    shift_bits(v, 0, L);
    push("t4.errL", S_ERR, 8'h00);
    push("t4.tailL", S_TAIL, {7'b0, v[L-1]});
    drain();
    shift_bits(v, L, 1);
    push("t4.err", S_ERR, 8'h01);
    push("t4.tail", S_TAIL, 8'h01);
    drain();
    end_window();
    push("t4.err_end", S_ERR, 8'h01);
    drain();
    pad_patterns("t4.keep");

    // 5: reset mid-window with enable held, load restarts
    v = make_vec(8'hB1, 1'b1);
    shift_bits(v, 0, 4);
    pReset_n = 1'b0;
    step();
    pReset_n = 1'b1;
    m_act = '0; m_valid = 1'b0;
    push("t5.val", S_VAL, 8'h00);
    push("t5.err", S_ERR, 8'h00);
    push("t5.tail", S_TAIL, 8'h00);
    drain();
    shift_bits(v, 0, L);
    end_window();
    m_act = 8'hB1; m_valid = 1'b1;
    push("t5.val2", S_VAL, 8'h01);
    push("t5.err2", S_ERR, 8'h00);
    drain();
    pad_patterns("t5");

`ifdef GRID_IO_CFG_PARITY_EN
    // 6: parity check
    v = make_vec(8'h5A, 1'b0);
    shift_bits(v, 0, L);
    end_window();
    push("t6.even_err", S_ERR, 8'h01);
    drain();
    pad_patterns("t6.keep");
    v = make_vec(8'h5A, 1'b1);
    shift_bits(v, 0, L);
    end_window();
    m_act = 8'h5A;
    push("t6.odd_err", S_ERR, 8'h00);
    push("t6.odd_val", S_VAL, 8'h01);
    drain();
    pad_patterns("t6.new");
`endif

    // one-cycle window
    v = make_vec(8'hFF, 1'b1);
    shift_bits(v, 0, 1);
    end_window();
    push("one.err", S_ERR, 8'h01);
    drain();
    pad_patterns("one.keep");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
